// File: rtl/phase_scheduler.sv
`default_nettype none
// ============================================================================
// Module   : phase_scheduler
// Purpose  : Two-path intersection right-of-way sequencer with pedestrian
//            walk windows and emergency preemption, advanced by a slow tick.
// Revision : 1.0  initial release
// ============================================================================

module phase_scheduler #(
  parameter int GREEN_TICKS  = 20,
  parameter int YELLOW_TICKS = 6,
  parameter int ALLRED_TICKS = 2,
  parameter int WALK_TICKS   = 10,
  parameter int CNT_W        = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             tick,
  input  logic             run,
  input  logic [1:0]       ped_req,
  input  logic             emerg_req,
  input  logic             emerg_path,
  output logic [3:0]       car_traffic_0,
  output logic [1:0]       walk_traffic_0,
  output logic [3:0]       car_traffic_1,
  output logic [1:0]       walk_traffic_1,
  output logic [2:0]       phase,
  output logic [CNT_W-1:0] remain,
  output logic [1:0]       ped_pending
);

  typedef enum logic [2:0] {
    ALLRED_0 = 3'd0,
    G0       = 3'd1,
    Y0       = 3'd2,
    ALLRED_1 = 3'd3,
    G1       = 3'd4,
    Y1       = 3'd5,
    PRE_G    = 3'd6,
    PRE_Y    = 3'd7
  } state_t;

  localparam logic [CNT_W-1:0] c_green_last  = CNT_W'(GREEN_TICKS - 1);
  localparam logic [CNT_W-1:0] c_yellow_last = CNT_W'(YELLOW_TICKS - 1);
  localparam logic [CNT_W-1:0] c_allred_last = CNT_W'(ALLRED_TICKS - 1);
  localparam logic [CNT_W-1:0] c_walk_floor  = CNT_W'(GREEN_TICKS - WALK_TICKS);

  localparam logic [3:0] c_car_red    = 4'b1000;
  localparam logic [3:0] c_car_yellow = 4'b0100;
  localparam logic [3:0] c_car_green  = 4'b0001;
  localparam logic [1:0] c_walk_red   = 2'b10;
  localparam logic [1:0] c_walk_green = 2'b01;

  state_t           r_state;
  state_t           w_state_n;
  logic [CNT_W-1:0] r_remain;
  logic [CNT_W-1:0] w_remain_n;
  logic [1:0]       r_ped;
  logic [1:0]       w_ped_n;
  logic [1:0]       r_walk_en;
  logic [1:0]       w_walk_en_n;
  logic             r_epath;
  logic             w_epath;
  logic             r_emerg_d;
  logic             w_rise;
  logic             w_tick_dec;
  logic             w_tick_end;
  logic             w_own;

  logic [3:0]       r_car0;
  logic [3:0]       r_car1;
  logic [1:0]       r_walk0;
  logic [1:0]       r_walk1;
  logic [3:0]       w_car0;
  logic [3:0]       w_car1;
  logic [1:0]       w_walk0;
  logic [1:0]       w_walk1;

  // The preempted path is frozen once preemption is in progress.
  assign w_rise     = emerg_req & ~r_emerg_d;
  assign w_epath    = (w_rise && (r_state != PRE_G) && (r_state != PRE_Y)) ? emerg_path : r_epath;
  assign w_tick_dec = tick & (r_remain != '0);
  assign w_tick_end = tick & (r_remain == '0);
  assign w_own      = (r_state == G1) || (r_state == Y1);

  always_comb begin
    w_state_n   = r_state;
    w_remain_n  = r_remain;
    w_ped_n     = r_ped | ped_req;
    w_walk_en_n = r_walk_en;

    case (r_state)
      ALLRED_0, ALLRED_1: begin
        if (w_tick_dec) begin
          w_remain_n = r_remain - 1'b1;
        end else if (w_tick_end && emerg_req) begin
          w_state_n  = PRE_G;
          w_remain_n = '0;
        end else if (w_tick_end && run) begin
          w_remain_n = c_green_last;
          // Entering a green serves the crossing path's pending request.
          if (r_state == ALLRED_1) begin
            w_state_n      = G0;
            w_walk_en_n[1] = r_ped[1];
            w_ped_n[1]     = ped_req[1];
          end else begin
            w_state_n      = G1;
            w_walk_en_n[0] = r_ped[0];
            w_ped_n[0]     = ped_req[0];
          end
        end
      end

      G0, G1: begin
        if (emerg_req && (w_own != w_epath)) begin
          w_walk_en_n = '0;
        end
        if (tick && emerg_req && (w_own == w_epath)) begin
          w_state_n   = PRE_G;
          w_remain_n  = '0;
          w_walk_en_n = '0;
        end else if (tick && emerg_req) begin
          w_state_n  = w_own ? Y1 : Y0;
          w_remain_n = c_yellow_last;
        end else if (w_tick_dec) begin
          w_remain_n = r_remain - 1'b1;
        end else if (w_tick_end) begin
          w_state_n  = w_own ? Y1 : Y0;
          w_remain_n = c_yellow_last;
        end
      end

      Y0, Y1: begin
        if (w_tick_dec) begin
          w_remain_n = r_remain - 1'b1;
        end else if (w_tick_end) begin
          w_state_n  = w_own ? ALLRED_1 : ALLRED_0;
          w_remain_n = c_allred_last;
        end
      end

      PRE_G: begin
        w_remain_n = '0;
        if (tick && !emerg_req) begin
          w_state_n  = PRE_Y;
          w_remain_n = c_yellow_last;
        end
      end

      PRE_Y: begin
        if (tick && emerg_req) begin
          w_state_n  = PRE_G;
          w_remain_n = '0;
        end else if (w_tick_dec) begin
          w_remain_n = r_remain - 1'b1;
        end else if (w_tick_end) begin
          w_state_n  = r_epath ? ALLRED_1 : ALLRED_0;
          w_remain_n = c_allred_last;
        end
      end

      default: begin
        w_state_n = r_state;
      end
    endcase
  end

  // Lights are decoded from the next state so they register on the same edge.
  always_comb begin
    w_car0  = c_car_red;
    w_car1  = c_car_red;
    w_walk0 = c_walk_red;
    w_walk1 = c_walk_red;

    case (w_state_n)
      G0: begin
        w_car0 = c_car_green;
        if (w_walk_en_n[1] && (w_remain_n >= c_walk_floor)) begin
          w_walk1 = c_walk_green;
        end
      end
      Y0: w_car0 = c_car_yellow;
      G1: begin
        w_car1 = c_car_green;
        if (w_walk_en_n[0] && (w_remain_n >= c_walk_floor)) begin
          w_walk0 = c_walk_green;
        end
      end
      Y1: w_car1 = c_car_yellow;
      PRE_G: begin
        if (w_epath) w_car1 = c_car_green;
        else         w_car0 = c_car_green;
      end
      PRE_Y: begin
        if (w_epath) w_car1 = c_car_yellow;
        else         w_car0 = c_car_yellow;
      end
      default: begin
        w_car0 = c_car_red;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= ALLRED_1;
      r_remain  <= c_allred_last;
      r_ped     <= '0;
      r_walk_en <= '0;
      r_epath   <= 1'b0;
      r_emerg_d <= 1'b0;
      r_car0    <= c_car_red;
      r_car1    <= c_car_red;
      r_walk0   <= c_walk_red;
      r_walk1   <= c_walk_red;
    end else begin
      r_state   <= w_state_n;
      r_remain  <= w_remain_n;
      r_ped     <= w_ped_n;
      r_walk_en <= w_walk_en_n;
      r_epath   <= w_epath;
      r_emerg_d <= emerg_req;
      r_car0    <= w_car0;
      r_car1    <= w_car1;
      r_walk0   <= w_walk0;
      r_walk1   <= w_walk1;
    end
  end

  assign car_traffic_0  = r_car0;
  assign car_traffic_1  = r_car1;
  assign walk_traffic_0 = r_walk0;
  assign walk_traffic_1 = r_walk1;
  assign phase          = r_state;
  assign remain         = r_remain;
  assign ped_pending    = r_ped;

endmodule

`default_nettype wire

// File: tb/tb_phase_scheduler.sv
`default_nettype none
// ============================================================================
// Module   : tb_phase_scheduler
// Purpose  : Directed plus randomized bench against a path-level reference.
// Revision : 1.0  initial release
// ============================================================================

module tb_phase_scheduler;

  localparam int GREEN = 20;
  localparam int YEL   = 6;
  localparam int AR    = 2;
  localparam int WALK  = 10;
  localparam int CW    = 8;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          tick = 1'b0;
  logic          run = 1'b0;
  logic [1:0]    ped_req = 2'b00;
  logic          emerg_req = 1'b0;
  logic          emerg_path = 1'b0;
  logic [3:0]    car_traffic_0, car_traffic_1;
  logic [1:0]    walk_traffic_0, walk_traffic_1;
  logic [2:0]    phase;
  logic [CW-1:0] remain;
  logic [1:0]    ped_pending;

  int checks = 0;
  int errors = 0;
  int tick_mode = 0;
  int tcnt = 0;

  always #5 clk = ~clk;

  phase_scheduler #(
    .GREEN_TICKS(GREEN), .YELLOW_TICKS(YEL), .ALLRED_TICKS(AR),
    .WALK_TICKS(WALK), .CNT_W(CW)
  ) dut (
    .clk(clk), .rst(rst), .tick(tick), .run(run), .ped_req(ped_req),
    .emerg_req(emerg_req), .emerg_path(emerg_path),
    .car_traffic_0(car_traffic_0), .walk_traffic_0(walk_traffic_0),
    .car_traffic_1(car_traffic_1), .walk_traffic_1(walk_traffic_1),
    .phase(phase), .remain(remain), .ped_pending(ped_pending)
  );

  // Reference: phase id, its length and ticks elapsed inside it.
  int         m_ph, m_len, m_el;
  logic [1:0] m_ped, m_walk;
  logic       m_epath, m_eprev;

  function automatic int green_of(int p);
    return (p == 0) ? 1 : 4;
  endfunction

  function automatic int yellow_of(int p);
    return (p == 0) ? 2 : 5;
  endfunction

  task automatic m_enter(input int ph, input int len);
    m_ph  = ph;
    m_len = len;
    m_el  = 0;
  endtask

  task automatic model_step();
    logic       rise;
    logic [1:0] nped;
    int         own;
    int         p;
    if (rst) begin
      m_enter(3, AR);
      m_ped = 2'b00; m_walk = 2'b00; m_epath = 1'b0; m_eprev = 1'b0;
      return;
    end
    rise    = emerg_req && !m_eprev;
    m_eprev = emerg_req;
    if (rise && m_ph < 6) m_epath = emerg_path;
    nped = m_ped | ped_req;
    own  = (m_ph >= 4) ? 1 : 0;
    if ((m_ph == 1 || m_ph == 4) && emerg_req && own != int'(m_epath)) m_walk = 2'b00;
    if (tick) begin
      if (emerg_req && (m_ph == 1 || m_ph == 4)) begin
        if (own == int'(m_epath)) begin
          m_enter(6, 1);
          m_walk = 2'b00;
        end else begin
          m_enter(yellow_of(own), YEL);
        end
      end else if (m_ph == 6) begin
        if (!emerg_req) m_enter(7, YEL);
      end else if (m_ph == 7 && emerg_req) begin
        m_enter(6, 1);
      end else if (m_el < m_len - 1) begin
        m_el++;
      end else begin
        case (m_ph)
          0, 3: begin
            if (emerg_req) m_enter(6, 1);
            else if (run) begin
              p = (m_ph == 3) ? 0 : 1;
              m_enter(green_of(p), GREEN);
              m_walk[1-p] = m_ped[1-p];
              nped[1-p]   = ped_req[1-p];
            end
          end
          1: m_enter(2, YEL);
          4: m_enter(5, YEL);
          2: m_enter(0, AR);
          5: m_enter(3, AR);
          7: m_enter(m_epath ? 3 : 0, AR);
          default: m_enter(m_ph, m_len);
        endcase
      end
    end
    m_ped = nped;
  endtask

  function automatic logic [3:0] exp_car(int p);
    if (m_ph == green_of(p) || (m_ph == 6 && int'(m_epath) == p)) return 4'b0001;
    if (m_ph == yellow_of(p) || (m_ph == 7 && int'(m_epath) == p)) return 4'b0100;
    return 4'b1000;
  endfunction

  function automatic logic [1:0] exp_walk(int k);
    return (m_ph == green_of(1 - k) && m_walk[k] && m_el < WALK) ? 2'b01 : 2'b10;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    case (tick_mode)
      0:       tick = (tcnt % 4 == 3);
      1:       tick = ($urandom_range(0, 2) == 0);
      default: tick = 1'b0;
    endcase
    tcnt++;
    model_step();
    @(posedge clk);
    #1;
    check("phase",  32'(phase),          32'(m_ph));
    check("remain", 32'(remain),         32'(m_len - 1 - m_el));
    check("car0",   32'(car_traffic_0),  32'(exp_car(0)));
    check("car1",   32'(car_traffic_1),  32'(exp_car(1)));
    check("walk0",  32'(walk_traffic_0), 32'(exp_walk(0)));
    check("walk1",  32'(walk_traffic_1), 32'(exp_walk(1)));
    check("ped",    32'(ped_pending),    32'(m_ped));
  endtask

  task automatic steps(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic wait_phase(input int ph, input int budget, input string tag);
    int n;
    n = 0;
    while (m_ph != ph && n < budget) begin
      step();
      n++;
    end
    check(tag, 32'(phase), 32'(ph));
  endtask

  initial begin
    // Reset for two cycles.
    steps(2);
    check("rst_phase", 32'(phase), 32'd3);
    check("rst_remain", 32'(remain), 32'(AR - 1));
    check("rst_car0", 32'(car_traffic_0), 32'h8);
    check("rst_walk1", 32'(walk_traffic_1), 32'h2);
    rst = 1'b0;
    run = 1'b1;

    // Two ticks of all-red, then path 0 green.
    wait_phase(1, 12, "first_g0");
    check("g0_car0", 32'(car_traffic_0), 32'h1);

    // Pedestrian on path 1 is held until the next path 0 green.
    steps(6);
    ped_req = 2'b10;
    step();
    ped_req = 2'b00;
    check("ped_latch", 32'(ped_pending), 32'h2);
    wait_phase(4, 200, "reach_g1");
    check("g1_walk1_red", 32'(walk_traffic_1), 32'h2);
    wait_phase(1, 200, "reach_g0_walk");
    check("g0_walk1_green", 32'(walk_traffic_1), 32'h1);
    check("ped_cleared", 32'(ped_pending), 32'h0);

    // Preempt toward path 1 during path 0 green.
    steps(19);
    emerg_req  = 1'b1;
    emerg_path = 1'b1;
    wait_phase(6, 200, "reach_pre_g");
    check("pre_g_car1", 32'(car_traffic_1), 32'h1);
    steps(12);
    emerg_req = 1'b0;
    wait_phase(7, 20, "reach_pre_y");
    wait_phase(3, 60, "pre_to_allred1");
    wait_phase(1, 40, "resume_g0");

    // Hold with run low.
    wait_phase(4, 400, "reach_g1_hold");
    steps(20);
    run = 1'b0;
    wait_phase(3, 400, "hold_allred1");
    steps(60);
    check("hold_phase", 32'(phase), 32'd3);
    check("hold_remain", 32'(remain), 32'd0);
    run = 1'b1;
    wait_phase(1, 8, "release_g0");

    // Reset in the middle of path 0 yellow, without a tick.
    wait_phase(2, 400, "reach_y0");
    tick_mode = 2;
    ped_req = 2'b11;
    step();
    ped_req = 2'b00;
    rst = 1'b1;
    step();
    check("mid_rst_phase", 32'(phase), 32'd3);
    check("mid_rst_car0", 32'(car_traffic_0), 32'h8);
    check("mid_rst_car1", 32'(car_traffic_1), 32'h8);
    check("mid_rst_walk0", 32'(walk_traffic_0), 32'h2);
    check("mid_rst_ped", 32'(ped_pending), 32'h0);
    rst = 1'b0;
    tick_mode = 0;

    // Request held across the green-entry clearing edge stays pending.
    ped_req = 2'b10;
    wait_phase(1, 40, "held_ped_g0");
    step();
    ped_req = 2'b00;
    check("held_ped", 32'(ped_pending), 32'h2);

    // Randomized traffic.
    tick_mode = 1;
    for (int i = 0; i < 4000; i++) begin
      if (run) run = ($urandom_range(0, 299) != 0);
      else     run = ($urandom_range(0, 39) == 0);
      ped_req = ($urandom_range(0, 29) == 0) ? 2'($urandom_range(0, 3)) : 2'b00;
      if ($urandom_range(0, 249) == 0) begin
        emerg_req  = ~emerg_req;
        emerg_path = 1'($urandom_range(0, 1));
      end
      rst = ($urandom_range(0, 1499) == 0);
      step();
    end
    rst = 1'b0;

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
